// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and helpers for the PLL lock sequencer: state encoding,
// timer-width derivation and saturating counter increment.
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    // Width needed for one timer to cover the longest interval without wrapping.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                 input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

    // Increment v, holding at 2^w-1 (w below 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (32'd1 << w) - 32'd1;
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and its PLL / reset consumers.
interface pll_lock_sequencer_if #(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned CNT_W   = 8
);
    import pll_seq_pkg::*;

    logic                 pll_locked_i;
    logic                 force_relock_i;
    logic                 pll_rst_o;
    logic [NUM_OUT-1:0]   rst_o;
    logic                 all_ready_o;
    logic [STATE_W-1:0]   state_o;
    logic [CNT_W-1:0]     lock_loss_cnt_o;
    logic [CNT_W-1:0]     retry_cnt_o;

    modport master (
        output pll_locked_i, force_relock_i,
        input  pll_rst_o, rst_o, all_ready_o, state_o, lock_loss_cnt_o, retry_cnt_o
    );

    modport slave (
        input  pll_locked_i, force_relock_i,
        output pll_rst_o, rst_o, all_ready_o, state_o, lock_loss_cnt_o, retry_cnt_o
    );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises PLL reset/lock from the reference clock and releases downstream
// reset channels in order once lock has been stable long enough.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT        = 4,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned STAGE_DELAY    = 256,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clkin,
    input  logic                rst,
    pll_lock_sequencer_if.slave bus
);
    localparam int unsigned RELEASE_LEN = STAGE_DELAY * NUM_OUT;
    localparam int unsigned TIMER_W     = timer_width(LOCK_TIMEOUT, LOCK_FILTER, RELEASE_LEN, PLL_RST_CYCLES);

    seq_state_e          state_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                pll_rst_q;
    logic [NUM_OUT-1:0]  rst_q;
    logic                ready_q;
    logic [CNT_W-1:0]    loss_q;
    logic [CNT_W-1:0]    retry_q;

    logic                locked_s;
    logic                running_c;
    logic                timeout_c;
    logic                loss_inc_c;
    logic                retry_inc_c;
    logic                relock_c;
    logic [NUM_OUT-1:0]  stage_hit_c;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (bus.pll_locked_i),
        .q   (locked_s)
    );

    // Relock decision; a force request takes precedence and never counts as a loss.
    always_comb begin
        running_c   = (state_q == ST_RELEASE) || (state_q == ST_RUN);
        timeout_c   = (state_q == ST_WAIT_LOCK) && !locked_s &&
                      (timer_q == TIMER_W'(LOCK_TIMEOUT - 1));
        loss_inc_c  = running_c && !locked_s && !bus.force_relock_i;
        retry_inc_c = timeout_c && !bus.force_relock_i;
        relock_c    = (state_q != ST_PLL_RST) &&
                      (bus.force_relock_i || loss_inc_c || timeout_c);
    end

    // Channel k drops when the release timer is about to reach (k+1)*STAGE_DELAY.
    always_comb begin
        stage_hit_c = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            stage_hit_c[k] = ((timer_q + TIMER_W'(1)) == TIMER_W'((k + 1) * STAGE_DELAY));
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            loss_q    <= '0;
            retry_q   <= '0;
        end else if (relock_c) begin
            state_q   <= ST_PLL_RST;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            if (loss_inc_c)  loss_q  <= CNT_W'(sat_inc(32'(loss_q), CNT_W));
            if (retry_inc_c) retry_q <= CNT_W'(sat_inc(32'(retry_q), CNT_W));
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (timer_q == TIMER_W'(PLL_RST_CYCLES - 1)) begin
                        state_q   <= ST_WAIT_LOCK;
                        timer_q   <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= ST_FILTER;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_FILTER: begin
                    if (!locked_s) begin
                        state_q <= ST_WAIT_LOCK;
                        timer_q <= '0;
                    end else if (timer_q == TIMER_W'(LOCK_FILTER - 1)) begin
                        state_q <= ST_RELEASE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_RELEASE: begin
                    rst_q <= rst_q & ~stage_hit_c;
                    if (timer_q == TIMER_W'(RELEASE_LEN - 1)) begin
                        state_q <= ST_RUN;
                        timer_q <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_RUN: begin
                    timer_q <= '0;
                end
                default: begin
                    state_q   <= ST_PLL_RST;
                    timer_q   <= '0;
                    pll_rst_q <= 1'b1;
                    rst_q     <= '1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst_o       = pll_rst_q;
    assign bus.rst_o           = rst_q;
    assign bus.all_ready_o     = ready_q;
    assign bus.state_o         = state_q;
    assign bus.lock_loss_cnt_o = loss_q;
    assign bus.retry_cnt_o     = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic clkin;
    logic rst;
    int   checks;
    int   errors;

    pll_lock_sequencer_if #(.NUM_OUT(3), .CNT_W(4)) bus ();

    pll_lock_sequencer #(
        .NUM_OUT        (3),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (50),
        .LOCK_FILTER    (8),
        .STAGE_DELAY    (5),
        .CNT_W          (4)
    ) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    localparam int REL_T[7]     = '{0, 4, 5, 9, 10, 14, 15};
    localparam int REL_RST[7]   = '{7, 7, 6, 6, 4, 4, 0};
    localparam int REL_STATE[7] = '{3, 3, 3, 3, 3, 3, 4};
    localparam int REL_READY[7] = '{0, 0, 0, 0, 0, 0, 1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (bus.state_o != s && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    // Ticks until state s is left and then entered again.
    task automatic wait_reentry(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (bus.state_o == s && n < budget) begin
            tick(1);
            n++;
        end
        while (bus.state_o != s && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int t;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.pll_locked_i   = 1'b0;
        bus.force_relock_i = 1'b0;

        // reset values
        #23;
        check_eq("rst_state",   32'(bus.state_o), 0);
        check_eq("rst_pll_rst", 32'(bus.pll_rst_o), 1);
        check_eq("rst_rst_o",   32'(bus.rst_o), 7);
        check_eq("rst_ready",   32'(bus.all_ready_o), 0);
        check_eq("rst_loss",    32'(bus.lock_loss_cnt_o), 0);
        check_eq("rst_retry",   32'(bus.retry_cnt_o), 0);

        // 1: clean lock-up
        @(negedge clkin);
        rst = 1'b0;
        n = 0;
        while (bus.pll_rst_o && n < 20) begin
            n++;
            tick(1);
        end
        check_eq("t1_pll_rst_len", n, 4);
        check_eq("t1_wait_lock",   32'(bus.state_o), 1);
        bus.pll_locked_i = 1'b1;
        wait_state(3'd2, 20, n);
        check_eq("t1_filter_lat", n, 3);
        wait_state(3'd3, 20, n);
        check_eq("t1_filter_len", n, 8);
        t = 0;
        for (int i = 0; i < 7; i++) begin
            tick(REL_T[i] - t);
            t = REL_T[i];
            check_eq($sformatf("t1_rst_o_T%0d", t), 32'(bus.rst_o), REL_RST[i]);
            check_eq($sformatf("t1_state_T%0d", t), 32'(bus.state_o), REL_STATE[i]);
            check_eq($sformatf("t1_ready_T%0d", t), 32'(bus.all_ready_o), REL_READY[i]);
        end
        check_eq("t1_loss",  32'(bus.lock_loss_cnt_o), 0);
        check_eq("t1_retry", 32'(bus.retry_cnt_o), 0);

        // 4: lock loss in RUN
        bus.pll_locked_i = 1'b0;
        tick(1);
        check_eq("t4_state_e1", 32'(bus.state_o), 4);
        tick(1);
        check_eq("t4_state_e2", 32'(bus.state_o), 4);
        check_eq("t4_rst_o_e2", 32'(bus.rst_o), 0);
        tick(1);
        check_eq("t4_state_e3", 32'(bus.state_o), 0);
        check_eq("t4_rst_o_e3", 32'(bus.rst_o), 7);
        check_eq("t4_ready_e3", 32'(bus.all_ready_o), 0);
        check_eq("t4_pll_rst",  32'(bus.pll_rst_o), 1);
        check_eq("t4_loss",     32'(bus.lock_loss_cnt_o), 1);
        bus.pll_locked_i = 1'b1;
        wait_state(3'd4, 200, n);
        check_eq("t4_rerun_state", 32'(bus.state_o), 4);
        check_eq("t4_rerun_ready", 32'(bus.all_ready_o), 1);
        check_eq("t4_rerun_rst_o", 32'(bus.rst_o), 0);

        // 5: force in RUN, then force coincident with loss in RELEASE
        bus.force_relock_i = 1'b1;
        tick(1);
        bus.force_relock_i = 1'b0;
        check_eq("t5_force_run_state", 32'(bus.state_o), 0);
        check_eq("t5_force_run_loss",  32'(bus.lock_loss_cnt_o), 1);
        n = 0;
        while (bus.rst_o != 3'b110 && n < 300) begin
            tick(1);
            n++;
        end
        check_eq("t5_reach_rel0", 32'(bus.rst_o), 6);
        bus.pll_locked_i = 1'b0;
        tick(2);
        check_eq("t5_pre_state", 32'(bus.state_o), 3);
        check_eq("t5_pre_rst_o", 32'(bus.rst_o), 6);
        bus.force_relock_i = 1'b1;
        tick(1);
        bus.force_relock_i = 1'b0;
        check_eq("t5_coinc_rst_o", 32'(bus.rst_o), 7);
        check_eq("t5_coinc_state", 32'(bus.state_o), 0);
        check_eq("t5_coinc_loss",  32'(bus.lock_loss_cnt_o), 1);
        n = 1;
        bus.force_relock_i = 1'b1;
        tick(1);
        bus.force_relock_i = 1'b0;
        while (bus.state_o == 3'd0 && n < 20) begin
            n++;
            tick(1);
        end
        check_eq("t5_pll_rst_force_len", n, 4);
        check_eq("t5_after_state",       32'(bus.state_o), 1);
        check_eq("t5_after_pll_rst",     32'(bus.pll_rst_o), 0);

        // 3: one-cycle glitch during FILTER
        bus.pll_locked_i = 1'b1;
        wait_state(3'd2, 20, n);
        check_eq("t3_reach_filter", 32'(bus.state_o), 2);
        tick(4);
        bus.pll_locked_i = 1'b0;
        tick(1);
        bus.pll_locked_i = 1'b1;
        tick(1);
        check_eq("t3_c6_state", 32'(bus.state_o), 2);
        check_eq("t3_c6_rst_o", 32'(bus.rst_o), 7);
        tick(1);
        check_eq("t3_c7_state", 32'(bus.state_o), 1);
        tick(1);
        check_eq("t3_c8_state", 32'(bus.state_o), 2);
        tick(7);
        check_eq("t3_c15_state", 32'(bus.state_o), 2);
        check_eq("t3_c15_rst_o", 32'(bus.rst_o), 7);
        tick(1);
        check_eq("t3_c16_state", 32'(bus.state_o), 3);
        check_eq("t3_loss",      32'(bus.lock_loss_cnt_o), 1);
        check_eq("t3_retry",     32'(bus.retry_cnt_o), 0);

        // 2: no lock -> periodic retries saturating at 15
        bus.force_relock_i = 1'b1;
        bus.pll_locked_i   = 1'b0;
        tick(1);
        bus.force_relock_i = 1'b0;
        check_eq("t2_start_state", 32'(bus.state_o), 0);
        check_eq("t2_start_loss",  32'(bus.lock_loss_cnt_o), 1);
        wait_reentry(3'd0, 100, n);
        check_eq("t2_period", n, 54);
        check_eq("t2_retry_1", 32'(bus.retry_cnt_o), 1);
        for (int i = 2; i <= 16; i++) begin
            wait_reentry(3'd0, 100, n);
            check_eq($sformatf("t2_retry_%0d", i), 32'(bus.retry_cnt_o), (i > 15) ? 15 : i);
        end
        check_eq("t2_loss", 32'(bus.lock_loss_cnt_o), 1);

        // 6: async reset mid-RELEASE
        bus.pll_locked_i = 1'b1;
        wait_state(3'd3, 300, n);
        check_eq("t6_reach_release", 32'(bus.state_o), 3);
        tick(7);
        check_eq("t6_mid_rst_o", 32'(bus.rst_o), 6);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_state",   32'(bus.state_o), 0);
        check_eq("t6_pll_rst", 32'(bus.pll_rst_o), 1);
        check_eq("t6_rst_o",   32'(bus.rst_o), 7);
        check_eq("t6_ready",   32'(bus.all_ready_o), 0);
        check_eq("t6_loss",    32'(bus.lock_loss_cnt_o), 0);
        check_eq("t6_retry",   32'(bus.retry_cnt_o), 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
